sprite_eval_ctrl: RTL and testbench

- Per-scanline sprite evaluation sequencer for the 64-entry, 32-bit OAM block RAM.
- On a start pulse it walks every OAM entry through the RAM's registered read port. It selects up to MAX_SPRITES entries whose vertical extent covers the requested scanline.
- Selected entries are written into the sprite line buffer, with the Y field replaced by the row offset.
- Sits between the video timing generator (start/scanline) and the sprite pixel fetch stage.

---
 rtl/sprite_eval_ctrl.sv | 152 +++++++++++++++
 tb/tb_sprite_eval_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_eval_ctrl.sv
// Per-scanline sprite evaluation sequencer.
// Walks all 64 OAM entries through the registered RAM read port, selects
// up to MAX_SPRITES entries covering the latched scanline (lowest index
// first) and writes them to the line buffer with Y replaced by row offset.
module sprite_eval_ctrl #(
    parameter int SPRITE_HEIGHT = 16,
    parameter int MAX_SPRITES   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  scanline,
    output logic [5:0]  oam_read_addr,
    input  logic [31:0] oam_read_data,
    output logic        sel_we,
    output logic [3:0]  sel_index,
    output logic [31:0] sel_data,
    output logic [3:0]  sel_count,
    output logic        overflow,
    output logic        busy,
    output logic        done
);

    localparam logic [8:0] HEIGHT9 = 9'(SPRITE_HEIGHT);
    localparam logic [3:0] MAXC    = 4'(MAX_SPRITES);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [5:0]  addr_q, addr_d;
    logic [7:0]  line_q, line_d;
    logic        rd_vld_q, rd_vld_d;   // oam_read_data carries a scanned entry this cycle
    logic        drain_q, drain_d;     // second DRAIN cycle
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        sel_we_q, sel_we_d;
    logic [3:0]  sel_index_q, sel_index_d;
    logic [31:0] sel_data_q, sel_data_d;
    logic [3:0]  sel_count_q, sel_count_d;
    logic        overflow_q, overflow_d;

    logic [7:0]  entry_y;
    logic [8:0]  diff;
    logic        hit;

    // Row offset at 9 bits: a borrow (diff[8]) means Y lies below the line, so no wrap-around hits.
    assign entry_y = oam_read_data[31:24];
    assign diff    = {1'b0, line_q} - {1'b0, entry_y};
    assign hit     = rd_vld_q && !diff[8] && ({1'b0, diff[7:0]} < HEIGHT9) && (entry_y != 8'hFF);

    // Next-state: sequencing plus selection of the entry currently on the read port.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        line_d      = line_q;
        rd_vld_d    = (state_q == SCAN);
        drain_d     = drain_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sel_we_d    = 1'b0;
        sel_index_d = sel_index_q;
        sel_data_d  = sel_data_q;
        sel_count_d = sel_count_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SCAN;
                    addr_d      = 6'd0;
                    line_d      = scanline;
                    sel_count_d = 4'd0;
                    overflow_d  = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            SCAN: begin
                if (addr_q == 6'd63) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    addr_d = addr_q + 6'd1;
                end
            end
            DRAIN: begin
                // Two cycles: one for the last read to return, one for its write.
                if (drain_q) begin
                    state_d = IDLE;
                    drain_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Hits only occur during SCAN/DRAIN, so they never collide with the start clear.
        if (hit) begin
            if (sel_count_q < MAXC) begin
                sel_we_d    = 1'b1;
                sel_index_d = sel_count_q;
                sel_data_d  = {diff[7:0], oam_read_data[23:0]};
                sel_count_d = sel_count_q + 4'd1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // State and registered outputs; async reset kills any in-flight write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= 6'd0;
            line_q      <= 8'd0;
            rd_vld_q    <= 1'b0;
            drain_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sel_we_q    <= 1'b0;
            sel_index_q <= 4'd0;
            sel_data_q  <= 32'd0;
            sel_count_q <= 4'd0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            line_q      <= line_d;
            rd_vld_q    <= rd_vld_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sel_we_q    <= sel_we_d;
            sel_index_q <= sel_index_d;
            sel_data_q  <= sel_data_d;
            sel_count_q <= sel_count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign oam_read_addr = addr_q;
    assign sel_we        = sel_we_q;
    assign sel_index     = sel_index_q;
    assign sel_data      = sel_data_q;
    assign sel_count     = sel_count_q;
    assign overflow      = overflow_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_sprite_eval_ctrl.sv
// Self-checking bench for sprite_eval_ctrl: OAM RAM model, behavioural
// scan model rebuilt on every accepted start, per-cycle output compare.
module tb_sprite_eval_ctrl;

    localparam int SH = 16;
    localparam int MS = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  scanline = 8'd0;
    logic [5:0]  oam_read_addr;
    logic [31:0] oam_read_data = 32'd0;
    logic        sel_we;
    logic [3:0]  sel_index;
    logic [31:0] sel_data;
    logic [3:0]  sel_count;
    logic        overflow;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    sprite_eval_ctrl #(.SPRITE_HEIGHT(SH), .MAX_SPRITES(MS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .scanline(scanline),
        .oam_read_addr(oam_read_addr), .oam_read_data(oam_read_data),
        .sel_we(sel_we), .sel_index(sel_index), .sel_data(sel_data),
        .sel_count(sel_count), .overflow(overflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // OAM block RAM with a registered read port
    logic [31:0] oam [64];
    always @(posedge clk) oam_read_data <= oam[oam_read_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    int          m_S = 0;
    bit          m_active = 0;
    bit          exp_we [128];
    logic [3:0]  exp_idx [128];
    logic [31:0] exp_data [128];
    int          cnt_at [128];
    int          m_cnt;
    int          m_ovf_cyc;

    // For each accepted start, list every write (relative cycle, slot, data)
    task automatic build_model(input int line);
        int cnt;
        int y;
        int row;
        cnt = 0;
        m_ovf_cyc = 1000;
        for (int j = 0; j < 128; j++) begin
            exp_we[j] = 0; exp_idx[j] = 0; exp_data[j] = 0;
        end
        for (int k = 0; k < 64; k++) begin
            y   = int'(oam[k][31:24]);
            row = line - y;
            if (y != 255 && row >= 0 && row < SH) begin
                if (cnt < MS) begin
                    exp_we[3+k]   = 1;
                    exp_idx[3+k]  = 4'(cnt);
                    exp_data[3+k] = {8'(row), oam[k][23:0]};
                    cnt++;
                end else if (m_ovf_cyc == 1000) begin
                    m_ovf_cyc = 3 + k;
                end
            end
        end
        m_cnt = cnt;
        cnt = 0;
        for (int j = 0; j < 128; j++) begin
            if (exp_we[j]) cnt++;
            cnt_at[j] = cnt;
        end
    endtask

    // Accept a start only when the model considers the block idle
    initial forever begin
        @(posedge clk);
        if (reset_n && start && (!m_active || (cyc - m_S) >= 67)) begin
            m_S = cyc;
            m_active = 1;
            build_model(int'(scanline));
        end
        cyc++;
    end

    initial forever begin
        @(negedge reset_n);
        m_active = 0;
    end

    // Per-cycle compare against the model
    initial forever begin
        int r;
        int ri;
        @(negedge clk);
        if (!reset_n || !m_active) begin
            chk("rst_busy", {31'b0, busy}, 0);
            chk("rst_done", {31'b0, done}, 0);
            chk("rst_we", {31'b0, sel_we}, 0);
            chk("rst_addr", {26'b0, oam_read_addr}, 0);
            chk("rst_count", {28'b0, sel_count}, 0);
            chk("rst_ovf", {31'b0, overflow}, 0);
            chk("rst_index", {28'b0, sel_index}, 0);
            chk("rst_data", sel_data, 0);
        end else begin
            r  = cyc - m_S;
            ri = (r > 127) ? 127 : r;
            chk("busy", {31'b0, busy}, {31'b0, (r >= 1 && r <= 66)});
            chk("done", {31'b0, done}, {31'b0, (r == 67)});
            chk("sel_we", {31'b0, sel_we}, {31'b0, (r <= 127) ? exp_we[ri] : 1'b0});
            if (r <= 127 && exp_we[ri]) begin
                chk("sel_index", {28'b0, sel_index}, {28'b0, exp_idx[ri]});
                chk("sel_data", sel_data, exp_data[ri]);
            end
            if (r >= 1 && r <= 64) chk("addr", {26'b0, oam_read_addr}, 32'(r - 1));
            chk("sel_count", {28'b0, sel_count}, 32'(cnt_at[ri]));
            chk("overflow", {31'b0, overflow}, {31'b0, (r >= m_ovf_cyc)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic oam_hide_all();
        for (int k = 0; k < 64; k++) oam[k] = {8'hFF, 24'($urandom)};
    endtask

    task automatic oam_boundary();
        oam_hide_all();
        oam[3]  = {8'd25, 24'hA1B2C3};
        oam[5]  = {8'd24, 24'h111111};
        oam[9]  = {8'd41, 24'h222222};
        oam[12] = {8'd40, 24'h333333};
    endtask

    // Start at the current cycle S, optionally pulse start again at S+pulse_at; returns at S+67
    task automatic run(input logic [7:0] line, input int pulse_at, input logic [7:0] pulse_line);
        start = 1'b1; scanline = line;
        tick(1);
        start = 1'b0;
        if (pulse_at > 0) begin
            tick(pulse_at - 1);
            start = 1'b1; scanline = pulse_line;
            tick(1);
            start = 1'b0;
            tick(66 - pulse_at);
        end else begin
            tick(66);
        end
    endtask

    initial begin
        int y;
        for (int k = 0; k < 64; k++) oam[k] = 32'd0;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // 1: reset mid-scan, then a fresh full scan
        oam_boundary();
        start = 1'b1; scanline = 8'd40;
        tick(1);
        start = 1'b0;
        tick(29);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_count", {28'b0, sel_count}, 0);
        chk("midrst_addr", {26'b0, oam_read_addr}, 0);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        run(8'd40, 0, 8'd0);
        chk("post_rst_done", {31'b0, done}, 1);
        tick(2);

        // 2: empty line
        oam_hide_all();
        run(8'd40, 0, 8'd0);
        chk("empty_done", {31'b0, done}, 1);
        chk("empty_count", {28'b0, sel_count}, 0);
        chk("empty_ovf", {31'b0, overflow}, 0);
        tick(1);

        // 3: boundary rows, with literal pins on the model
        oam_boundary();
        run(8'd40, 0, 8'd0);
        chk("pin_we6", {31'b0, exp_we[6]}, 1);
        chk("pin_idx6", {28'b0, exp_idx[6]}, 0);
        chk("pin_row6", {24'b0, exp_data[6][31:24]}, 15);
        chk("pin_we15", {31'b0, exp_we[15]}, 1);
        chk("pin_idx15", {28'b0, exp_idx[15]}, 1);
        chk("pin_row15", {24'b0, exp_data[15][31:24]}, 0);
        chk("pin_we8", {31'b0, exp_we[8]}, 0);
        chk("bound_count", {28'b0, sel_count}, 2);
        chk("bound_data", sel_data, 32'h00333333);
        tick(1);

        // 4: overflow
        oam_hide_all();
        for (int k = 0; k < 10; k++) oam[k] = {8'd100, 24'($urandom)};
        run(8'd100, 0, 8'd0);
        chk("pin_ovf_cyc", 32'(m_ovf_cyc), 11);
        chk("ovf_count", {28'b0, sel_count}, 8);
        chk("ovf_flag", {31'b0, overflow}, 1);
        chk("ovf_index", {28'b0, sel_index}, 7);
        tick(1);

        // 5: start ignored mid-scan, then back-to-back start at S+67
        oam_boundary();
        run(8'd40, 20, 8'd30);
        chk("ign_count", {28'b0, sel_count}, 2);
        chk("ign_done", {31'b0, done}, 1);
        oam_hide_all();
        for (int k = 0; k < 10; k++) oam[k] = {8'd100, 24'($urandom)};
        run(8'd100, 0, 8'd0);
        chk("b2b_count", {28'b0, sel_count}, 8);
        chk("b2b_ovf", {31'b0, overflow}, 1);
        tick(1);

        // 6: no wrap-around
        oam_hide_all();
        oam[0] = {8'd250, 24'h445566};
        oam[1] = {8'd0, 24'h778899};
        run(8'd5, 0, 8'd0);
        chk("wrap_count", {28'b0, sel_count}, 1);
        chk("wrap_data", sel_data, {8'd5, 24'h778899});
        chk("wrap_index", {28'b0, sel_index}, 0);
        tick(1);

        // Randomized scans
        for (int n = 0; n < 30; n++) begin
            logic [7:0] line;
            line = 8'($urandom);
            for (int k = 0; k < 64; k++) begin
                case ($urandom_range(0, 3))
                    0: y = 255;
                    1: y = int'($urandom_range(0, 255));
                    default: y = (int'(line) - int'($urandom_range(0, SH + 2)) + 2) & 255;
                endcase
                oam[k] = {8'(y), 24'($urandom)};
            end
            run(line, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 65)) : 0, 8'($urandom));
            tick(int'($urandom_range(0, 3)));
        end

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
